ids_bus_rr_xbar: RTL and testbench

//  Parametrised shared-bus interconnect for the IDS SoC: NM requesting masters, NS address-decoded slaves.

---
 rtl/ids_bus_pkg.sv | 15 +
 rtl/ids_rr_arbiter.sv | 26 ++
 rtl/ids_bus_rr_xbar.sv | 104 ++++++++++
 tb/tb_ids_bus_rr_xbar.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ids_bus_pkg.sv
// ids_bus_pkg: shared types, constants and address decode for the IDS shared bus
package ids_bus_pkg;
  localparam int BUS_XLEN = 32;
  localparam logic [31:0] DECERR_DATA = 32'hDEAD_BEEF;
  typedef struct packed {
    logic [BUS_XLEN-1:0] addr;
    logic                write;
    logic                read;
    logic [3:0]          size;
    logic [BUS_XLEN-1:0] din;
  } bus_cmd_t;
  function automatic logic addr_decode(input logic [BUS_XLEN-1:0] addr, base, mask);
    return (addr & mask) == base;
  endfunction
endpackage

// File: rtl/ids_rr_arbiter.sv
// ids_rr_arbiter: round-robin arbiter, winner is first requester at or after rr_ptr
module ids_rr_arbiter #(
  parameter int N = 2,
  localparam int IW = N > 1 ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx
);
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] cand;
  always_comb begin
    o_idx = '0;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = IW'((int'(rr_ptr) + k) % N);
      if (i_req[cand]) o_idx = cand;
    end
    o_gnt = (i_rst || !(|i_req)) ? '0 : N'(1) << o_idx;
  end
  always_ff @(posedge i_clk)
    if (i_rst) rr_ptr <= '0;
    else if (|i_req) rr_ptr <= (int'(o_idx) == N - 1) ? '0 : o_idx + 1'b1;
endmodule

// File: rtl/ids_bus_rr_xbar.sv
// ids_bus_rr_xbar: NM-master / NS-slave shared bus, round-robin grant, 1-cycle read return.
// IDS_BUS_DECERR_EN: unmapped accesses flag o_mst_err and read back DECERR_DATA.
module ids_bus_rr_xbar
  import ids_bus_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NM = 2,
  parameter int NS = 3,
  parameter logic [NS*XLEN-1:0] SLV_BASE = {NS{32'h0}},
  parameter logic [NS*XLEN-1:0] SLV_MASK = {NS{32'hFFFF_0000}}
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NM-1:0]      i_mst_req,
  output logic [NM-1:0]      o_mst_gnt,
  input  logic [NM*XLEN-1:0] i_mst_addr,
  input  logic [NM-1:0]      i_mst_write,
  input  logic [NM-1:0]      i_mst_read,
  input  logic [NM*4-1:0]    i_mst_size,
  input  logic [NM*XLEN-1:0] i_mst_din,
  output logic [XLEN-1:0]    o_mst_dout,
  output logic [NM-1:0]      o_mst_rvalid,
  output logic [NM-1:0]      o_mst_err,
  output logic [NS-1:0]      o_slv_sel,
  output logic [XLEN-1:0]    o_slv_addr,
  output logic               o_slv_write,
  output logic               o_slv_read,
  output logic [3:0]         o_slv_size,
  output logic [XLEN-1:0]    o_slv_din,
  input  logic [NS*XLEN-1:0] i_slv_dout
);
  localparam int MW = NM > 1 ? $clog2(NM) : 1;
  localparam int SW = NS > 1 ? $clog2(NS) : 1;
`ifdef IDS_BUS_DECERR_EN
  localparam logic [XLEN-1:0] MISS_DATA = XLEN'(DECERR_DATA);
  logic err_pend;
`else
  localparam logic [XLEN-1:0] MISS_DATA = '0;
`endif
  logic [MW-1:0] widx;
  logic          act;
  bus_cmd_t      cmd;
  logic [NS-1:0] hit;
  logic [SW-1:0] sidx;
  logic          mapped;
  logic          rd_pend;
  logic          rd_map;
  logic [MW-1:0] rd_mst;
  logic [SW-1:0] rd_slv;
  ids_rr_arbiter #(.N(NM)) u_arb (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_req (i_mst_req),
    .o_gnt (o_mst_gnt),
    .o_idx (widx)
  );
  always_comb begin
    cmd.addr  = i_mst_addr[widx*XLEN +: XLEN];
    cmd.write = i_mst_write[widx];
    cmd.read  = i_mst_read[widx];
    cmd.size  = i_mst_size[widx*4 +: 4];
    cmd.din   = i_mst_din[widx*XLEN +: XLEN];
    act = |o_mst_gnt;
    hit = '0;
    sidx = '0;
    for (int s = NS - 1; s >= 0; s--) begin
      hit[s] = addr_decode(cmd.addr, SLV_BASE[s*XLEN +: XLEN], SLV_MASK[s*XLEN +: XLEN]);
      if (hit[s]) sidx = SW'(s);
    end
    mapped = |hit;
    // unmapped accesses are granted but never reach a slave
    o_slv_sel   = (act && mapped) ? NS'(1) << sidx : '0;
    o_slv_write = act && mapped && cmd.write;
    o_slv_read  = act && mapped && cmd.read && !cmd.write;
    o_slv_addr  = act ? cmd.addr : '0;
    o_slv_size  = act ? cmd.size : '0;
    o_slv_din   = act ? cmd.din : '0;
    o_mst_rvalid = (rd_pend && !i_rst) ? NM'(1) << rd_mst : '0;
    o_mst_dout = (!rd_pend || i_rst) ? '0 : rd_map ? i_slv_dout[rd_slv*XLEN +: XLEN] : MISS_DATA;
`ifdef IDS_BUS_DECERR_EN
    o_mst_err = (err_pend && !i_rst) ? NM'(1) << rd_mst : '0;
`else
    o_mst_err = '0;
`endif
  end
  always_ff @(posedge i_clk)
    if (i_rst) begin
      rd_pend <= 1'b0;
      rd_map  <= 1'b0;
      rd_mst  <= '0;
      rd_slv  <= '0;
`ifdef IDS_BUS_DECERR_EN
      err_pend <= 1'b0;
`endif
    end else begin
      rd_pend <= act && cmd.read && !cmd.write;
      rd_map  <= mapped;
      rd_mst  <= widx;
      rd_slv  <= sidx;
`ifdef IDS_BUS_DECERR_EN
      err_pend <= act && !mapped;
`endif
    end
endmodule

// File: tb/tb_ids_bus_rr_xbar.sv
// tb_ids_bus_rr_xbar: randomized scoreboard bench for ids_bus_rr_xbar against a transaction-level model
module tb_ids_bus_rr_xbar;
  localparam int NM = 2;
  localparam int NS = 3;
  localparam int NCYC = 3000;
  localparam logic [NS*32-1:0] BASE = {32'h8000_0000, 32'h1000_0000, 32'h4000_0000};
  localparam logic [NS*32-1:0] MASK = {NS{32'hFFFF_0000}};
  typedef struct {
    int            cyc;
    logic [NM-1:0] gnt;
    logic [NS-1:0] sel;
    logic          wr;
    logic          rd;
    logic [31:0]   addr;
    logic [3:0]    size;
    logic [31:0]   din;
    logic [NM-1:0] err;
  } iss_t;
  typedef struct {
    int          cyc;
    int          m;
    logic [31:0] dout;
  } rd_t;
  logic            clk;
  logic            rst;
  logic [NM-1:0]   mst_req, mst_gnt, mst_write, mst_read, mst_rvalid, mst_err;
  logic [NM*32-1:0] mst_addr, mst_din;
  logic [NM*4-1:0] mst_size;
  logic [31:0]     mst_dout, slv_addr, slv_din;
  logic [NS-1:0]   slv_sel;
  logic            slv_write, slv_read;
  logic [3:0]      slv_size;
  logic [NS*32-1:0] slv_dout;
  iss_t iss_q[$];
  rd_t  rd_q[$];
  iss_t exp_i, got_i;
  rd_t  got_r;
  int checks, failures, cyc;
  int ptr, gw, perr, s;
  logic rst_now, idle;
  logic [31:0] nxt_dout[NS];
  logic [31:0] map_base[NS] = '{32'h4000_0000, 32'h1000_0000, 32'h8000_0000};
  logic [15:0] regions[4] = '{16'h4000, 16'h1000, 16'h8000, 16'h2000};
  ids_bus_rr_xbar #(.XLEN(32), .NM(NM), .NS(NS), .SLV_BASE(BASE), .SLV_MASK(MASK)) dut (
    .i_clk(clk), .i_rst(rst), .i_mst_req(mst_req), .o_mst_gnt(mst_gnt),
    .i_mst_addr(mst_addr), .i_mst_write(mst_write), .i_mst_read(mst_read),
    .i_mst_size(mst_size), .i_mst_din(mst_din), .o_mst_dout(mst_dout),
    .o_mst_rvalid(mst_rvalid), .o_mst_err(mst_err), .o_slv_sel(slv_sel),
    .o_slv_addr(slv_addr), .o_slv_write(slv_write), .o_slv_read(slv_read),
    .o_slv_size(slv_size), .o_slv_din(slv_din), .i_slv_dout(slv_dout)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < NS; i++) if ((a & 32'hFFFF_0000) == map_base[i]) return i;
    return -1;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask
  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 1'b1; mst_req = '0; mst_addr = '0; mst_write = '0; mst_read = '0;
    mst_size = '0; mst_din = '0; slv_dout = '0;
    ptr = 0; gw = -1; perr = -1;
    for (int i = 0; i < NS; i++) nxt_dout[i] = $urandom;
    for (int c = 0; c < NCYC; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      rst_now = (c < 3) || ($urandom_range(0, 59) == 0);
      idle = c >= NCYC - 10;
      rst = rst_now;
      for (int i = 0; i < NS; i++) begin
        slv_dout[i*32 +: 32] = nxt_dout[i];
        nxt_dout[i] = $urandom;
      end
      if (gw >= 0) mst_req[gw] = 1'b0;
      for (int m = 0; m < NM; m++) begin
        if (idle) mst_req[m] = 1'b0;
        else if (mst_req[m] && $urandom_range(0, 15) == 0) mst_req[m] = 1'b0;
        else if (!mst_req[m] && $urandom_range(0, 2) != 0) begin
          mst_req[m] = 1'b1;
          mst_addr[m*32 +: 32] = {regions[$urandom_range(0, 3)], 16'($urandom)};
          mst_write[m] = 1'($urandom_range(0, 1));
          mst_read[m] = 1'($urandom_range(0, 1));
          mst_size[m*4 +: 4] = 4'($urandom);
          mst_din[m*32 +: 32] = $urandom;
        end
      end
      exp_i = '{cyc: c, gnt: '0, sel: '0, wr: 1'b0, rd: 1'b0, addr: '0, size: '0, din: '0, err: '0};
      if (rst_now) begin
        ptr = 0; gw = -1; perr = -1;
        if (rd_q.size() > 0 && rd_q[$].cyc == c) void'(rd_q.pop_back());
      end else begin
        exp_i.err = perr >= 0 ? NM'(1) << perr : '0;
        perr = -1; gw = -1;
        for (int k = NM - 1; k >= 0; k--) if (mst_req[(ptr + k) % NM]) gw = (ptr + k) % NM;
        if (gw >= 0) begin
          ptr = (gw + 1) % NM;
          s = decode(mst_addr[gw*32 +: 32]);
          exp_i.gnt = NM'(1) << gw;
          exp_i.addr = mst_addr[gw*32 +: 32];
          exp_i.size = mst_size[gw*4 +: 4];
          exp_i.din = mst_din[gw*32 +: 32];
          if (s >= 0) begin
            exp_i.sel = NS'(1) << s;
            exp_i.wr = mst_write[gw];
            exp_i.rd = mst_read[gw] && !mst_write[gw];
          end
`ifdef IDS_BUS_DECERR_EN
          if (s < 0) perr = gw;
          if (mst_read[gw] && !mst_write[gw]) rd_q.push_back('{c + 1, gw, s >= 0 ? nxt_dout[s] : 32'hDEAD_BEEF});
`else
          if (mst_read[gw] && !mst_write[gw]) rd_q.push_back('{c + 1, gw, s >= 0 ? nxt_dout[s] : 32'h0});
`endif
        end
      end
      iss_q.push_back(exp_i);
    end
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (rd_q.size() != 0 || iss_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending_reads=%0d pending_issues=%0d want=0", rd_q.size(), iss_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  always @(negedge clk) begin
    if (iss_q.size() > 0) begin
      got_i = iss_q.pop_front();
      chk("gnt", 32'(mst_gnt), 32'(got_i.gnt));
      chk("slv_sel", 32'(slv_sel), 32'(got_i.sel));
      chk("slv_write", 32'(slv_write), 32'(got_i.wr));
      chk("slv_read", 32'(slv_read), 32'(got_i.rd));
      chk("mst_err", 32'(mst_err), 32'(got_i.err));
      if (got_i.gnt != '0) begin
        chk("slv_addr", slv_addr, got_i.addr);
        chk("slv_size", 32'(slv_size), 32'(got_i.size));
        chk("slv_din", slv_din, got_i.din);
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == got_i.cyc) begin
        got_r = rd_q.pop_front();
        chk("rvalid", 32'(mst_rvalid), 32'(NM'(1) << got_r.m));
        chk("dout", mst_dout, got_r.dout);
      end else begin
        chk("rvalid_idle", 32'(mst_rvalid), 32'h0);
        chk("dout_idle", mst_dout, 32'h0);
      end
    end
  end
endmodule
